// File: rtl/johnson_monitor.sv
// Observer for a 4-bit Johnson counter: decodes its phase, tracks sequence
// against the counter's own enable, and reports wraps and code/sequence errors.
module johnson_monitor (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] count,
  input  logic       clr_err,
  output logic [2:0] phase,
  output logic [7:0] phase_onehot,
  output logic       phase_valid,
  output logic       locked,
  output logic       wrap_pulse,
  output logic [7:0] wrap_count,
  output logic       illegal_code,
  output logic       seq_error,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] count_q;
  logic       en_q;
  logic       hist_valid;

  logic       legal;
  logic [2:0] dec_phase;
  logic [3:0] expected;
  logic       seq_mismatch;
  logic       wrap_evt;
  logic       ill_evt;
  logic       seq_evt;
  logic       err_evt;

  always_comb begin
    legal     = 1'b1;
    dec_phase = 3'd0;
    case (count)
      4'b0000: dec_phase = 3'd0;
      4'b0001: dec_phase = 3'd1;
      4'b0011: dec_phase = 3'd2;
      4'b0111: dec_phase = 3'd3;
      4'b1111: dec_phase = 3'd4;
      4'b1110: dec_phase = 3'd5;
      4'b1100: dec_phase = 3'd6;
      4'b1000: dec_phase = 3'd7;
      default: legal     = 1'b0;
    endcase
  end

  // The counter only advances when its enable was high on the previous edge.
  assign expected     = en_q ? {count_q[2:0], ~count_q[3]} : count_q;
  assign seq_mismatch = hist_valid && (count != expected);

  always_comb begin
    state_nxt = state;
    ill_evt   = 1'b0;
    seq_evt   = 1'b0;
    wrap_evt  = (state == TRACK) && (count_q == 4'b1000) && en_q && (count == 4'b0000);
    case (state)
      ACQUIRE: begin
        if (legal) state_nxt = TRACK;
        else       ill_evt   = 1'b1;
      end
      TRACK: begin
        if (!legal) begin
          state_nxt = FAULT;
          ill_evt   = 1'b1;
        end else if (seq_mismatch) begin
          state_nxt = FAULT;
          seq_evt   = 1'b1;
        end
      end
      FAULT: begin
        if (!legal) ill_evt = 1'b1;
      end
      default: state_nxt = ACQUIRE;
    endcase
    // Clear wins over anything detected on the same edge.
    if (clr_err) begin
      state_nxt = ACQUIRE;
      ill_evt   = 1'b0;
      seq_evt   = 1'b0;
      wrap_evt  = 1'b0;
    end
  end

  assign err_evt = ill_evt | seq_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACQUIRE;
      count_q      <= '0;
      en_q         <= 1'b0;
      hist_valid   <= 1'b0;
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      locked       <= 1'b0;
      wrap_pulse   <= 1'b0;
      wrap_count   <= '0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      err_count    <= '0;
    end else begin
      state       <= state_nxt;
      count_q     <= count;
      en_q        <= en;
      hist_valid  <= 1'b1;
      locked      <= (state_nxt == TRACK);
      phase_valid <= legal;
      if (legal) begin
        phase        <= dec_phase;
        phase_onehot <= 8'd1 << dec_phase;
      end else begin
        phase_onehot <= '0;
      end
      wrap_pulse <= wrap_evt;
      if (clr_err) begin
        wrap_count   <= '0;
        illegal_code <= 1'b0;
        seq_error    <= 1'b0;
        err_count    <= '0;
      end else begin
        if (wrap_evt) wrap_count <= wrap_count + 8'd1;
        if (ill_evt)  illegal_code <= 1'b1;
        if (seq_evt)  seq_error <= 1'b1;
        if (err_evt && (err_count != '1)) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
